// File: rtl/register_file_package.sv
// Shared register-file constants and the write request record used by the writeback queue.
package register_file_package;
  localparam int ADDRESS_WIDTH  = 2;
  localparam int DATA_WIDTH     = 32;
  localparam int REGISTER_COUNT = 1 << ADDRESS_WIDTH;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] register;
    logic [DATA_WIDTH-1:0]    data;
  } write_request;
endpackage

// File: rtl/register_writeback_bypass.sv
// Youngest-match search over the pending entries of the writeback queue for one lookup port.
module register_writeback_bypass
  import register_file_package::*;
#(
  parameter int DEPTH         = 4,
  parameter int DATA_WIDTH    = register_file_package::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = register_file_package::ADDRESS_WIDTH
) (
  input  logic [ADDRESS_WIDTH-1:0] entry_register [DEPTH],
  input  logic [DATA_WIDTH-1:0]    entry_data     [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [ADDRESS_WIDTH-1:0] lookup,
  output logic                     hit,
  output logic [DATA_WIDTH-1:0]    data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] slot;

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entry_register[slot] == lookup)) begin
        hit  = 1'b1;
        data = entry_data[slot];
      end
    end
  end
endmodule

// File: rtl/register_writeback_queue.sv
// Circular writeback FIFO draining one register write per cycle, with optional read bypass.
// Bypass compare logic is built only when WRITEBACK_BYPASS_EN is defined.
module register_writeback_queue #(
  parameter int DEPTH         = 4,
  parameter int DATA_WIDTH    = register_file_package::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = register_file_package::ADDRESS_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request_valid,
  output logic                     request_ready,
  input  logic [ADDRESS_WIDTH-1:0] request_register,
  input  logic [DATA_WIDTH-1:0]    request_data,
  output logic [ADDRESS_WIDTH-1:0] write_register,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] lookup_register_port_0,
  input  logic [ADDRESS_WIDTH-1:0] lookup_register_port_1,
  output logic                     bypass_hit_port_0,
  output logic                     bypass_hit_port_1,
  output logic [DATA_WIDTH-1:0]    bypass_data_port_0,
  output logic [DATA_WIDTH-1:0]    bypass_data_port_1,
  output logic [$clog2(DEPTH):0]   pending_count
);
  import register_file_package::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] entry_register [DEPTH];
  logic [DATA_WIDTH-1:0]    entry_data     [DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [CNT_W-1:0]         count;
  logic                     accept;
  logic                     pop;

  assign request_ready  = (count < CNT_W'(DEPTH));
  assign accept         = request_valid && request_ready;
  assign write_enable   = (count != '0);
  assign pop            = write_enable;
  assign write_register = write_enable ? entry_register[head] : '0;
  assign write_data     = write_enable ? entry_data[head]     : '0;
  assign pending_count  = count;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      count <= count + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (accept && !reset) begin
      entry_register[tail] <= request_register;
      entry_data[tail]     <= request_data;
    end
  end

`ifdef WRITEBACK_BYPASS_EN
  register_writeback_bypass #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) bypass_port_0 (
    .entry_register(entry_register),
    .entry_data    (entry_data),
    .head          (head),
    .count         (count),
    .lookup        (lookup_register_port_0),
    .hit           (bypass_hit_port_0),
    .data          (bypass_data_port_0)
  );

  register_writeback_bypass #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) bypass_port_1 (
    .entry_register(entry_register),
    .entry_data    (entry_data),
    .head          (head),
    .count         (count),
    .lookup        (lookup_register_port_1),
    .hit           (bypass_hit_port_1),
    .data          (bypass_data_port_1)
  );
`else
  assign bypass_hit_port_0  = 1'b0;
  assign bypass_hit_port_1  = 1'b0;
  assign bypass_data_port_0 = '0;
  assign bypass_data_port_1 = '0;

  logic unused_lookup;
  assign unused_lookup = ^{lookup_register_port_0, lookup_register_port_1};
`endif
endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed bench for register_writeback_queue; bypass expectations follow WRITEBACK_BYPASS_EN.
module tb_register_writeback_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 2;
`ifdef WRITEBACK_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 request_valid;
  logic                 request_ready;
  logic [AW-1:0]        request_register;
  logic [DW-1:0]        request_data;
  logic [AW-1:0]        write_register;
  logic [DW-1:0]        write_data;
  logic                 write_enable;
  logic [AW-1:0]        lookup_register_port_0;
  logic [AW-1:0]        lookup_register_port_1;
  logic                 bypass_hit_port_0;
  logic                 bypass_hit_port_1;
  logic [DW-1:0]        bypass_data_port_0;
  logic [DW-1:0]        bypass_data_port_1;
  logic [$clog2(DEPTH):0] pending_count;

  int tests  = 0;
  int errors = 0;
  int writes_seen;

  register_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .request_valid         (request_valid),
    .request_ready         (request_ready),
    .request_register      (request_register),
    .request_data          (request_data),
    .write_register        (write_register),
    .write_data            (write_data),
    .write_enable          (write_enable),
    .lookup_register_port_0(lookup_register_port_0),
    .lookup_register_port_1(lookup_register_port_1),
    .bypass_hit_port_0     (bypass_hit_port_0),
    .bypass_hit_port_1     (bypass_hit_port_1),
    .bypass_data_port_0    (bypass_data_port_0),
    .bypass_data_port_1    (bypass_data_port_1),
    .pending_count         (pending_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    request_valid    = v;
    request_register = r;
    request_data     = d;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0);
    lookup_register_port_0 = '0;
    lookup_register_port_1 = '0;
    step();
    step();
    reset = 1'b0;

    // State right after reset
    check("rst_ready", 64'(request_ready), 64'd1);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_wreg", 64'(write_register), 64'd0);
    check("rst_wdata", 64'(write_data), 64'd0);
    check("rst_hit0", 64'(bypass_hit_port_0), 64'd0);
    check("rst_hit1", 64'(bypass_hit_port_1), 64'd0);
    check("rst_bdata0", 64'(bypass_data_port_0), 64'd0);
    check("rst_bdata1", 64'(bypass_data_port_1), 64'd0);
    check("rst_count", 64'(pending_count), 64'd0);

    // Single push, one-cycle latency, then empty
    drive(1'b1, 2'd0, 32'd21);
    step();
    drive(1'b0, '0, '0);
    check("single_we", 64'(write_enable), 64'd1);
    check("single_wreg", 64'(write_register), 64'd0);
    check("single_wdata", 64'(write_data), 64'd21);
    check("single_count", 64'(pending_count), 64'd1);
    step();
    check("single_we_off", 64'(write_enable), 64'd0);
    check("single_count_off", 64'(pending_count), 64'd0);
    check("single_wdata_off", 64'(write_data), 64'd0);

    // Back-to-back pushes drain in order, count never above 1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), DW'(21 << i));
      step();
      check("b2b_we", 64'(write_enable), 64'd1);
      check("b2b_wreg", 64'(write_register), 64'(i));
      check("b2b_wdata", 64'(write_data), 64'(21 << i));
      check("b2b_count", 64'(pending_count), 64'd1);
    end
    drive(1'b0, '0, '0);
    step();
    check("b2b_we_off", 64'(write_enable), 64'd0);
    check("b2b_count_off", 64'(pending_count), 64'd0);

    // Continuous pushes past DEPTH: ready stays high, pointers wrap cleanly
    writes_seen = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(1'b1, AW'(3 - (i % 4)), DW'(100 + i));
      check("stream_ready", 64'(request_ready), 64'd1);
      step();
      if (write_enable) writes_seen++;
      check("stream_wdata", 64'(write_data), 64'(100 + i));
      check("stream_wreg", 64'(write_register), 64'(3 - (i % 4)));
    end
    drive(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (write_enable) writes_seen++;
    end
    check("stream_writes", 64'(writes_seen), 64'(DEPTH + 3));
    check("stream_we_off", 64'(write_enable), 64'd0);

    // Bypass: youngest pending write to register 2
    lookup_register_port_0 = 2'd2;
    lookup_register_port_1 = 2'd3;
    check("byp_empty_hit0", 64'(bypass_hit_port_0), 64'd0);
    drive(1'b1, 2'd2, 32'd84);
    step();
    check("byp_first_hit0", 64'(bypass_hit_port_0), 64'(BYP));
    check("byp_first_data0", 64'(bypass_data_port_0), BYP ? 64'd84 : 64'd0);
    check("byp_first_hit1", 64'(bypass_hit_port_1), 64'd0);
    check("byp_first_data1", 64'(bypass_data_port_1), 64'd0);
    check("byp_first_wdata", 64'(write_data), 64'd84);
    drive(1'b1, 2'd2, 32'd99);
    step();
    drive(1'b0, '0, '0);
    check("byp_second_hit0", 64'(bypass_hit_port_0), 64'(BYP));
    check("byp_second_data0", 64'(bypass_data_port_0), BYP ? 64'd99 : 64'd0);
    check("byp_second_wdata", 64'(write_data), 64'd99);
    lookup_register_port_1 = 2'd2;
    #1;
    check("byp_port1_hit", 64'(bypass_hit_port_1), 64'(BYP));
    check("byp_port1_data", 64'(bypass_data_port_1), BYP ? 64'd99 : 64'd0);
    step();
    check("byp_drained_hit0", 64'(bypass_hit_port_0), 64'd0);
    check("byp_drained_data0", 64'(bypass_data_port_0), 64'd0);
    check("byp_drained_hit1", 64'(bypass_hit_port_1), 64'd0);

    // Reset while an entry is pending and a request is offered
    drive(1'b1, 2'd1, 32'd7);
    step();
    check("mid_we", 64'(write_enable), 64'd1);
    reset = 1'b1;
    drive(1'b1, 2'd3, 32'd5);
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0);
    check("mid_rst_we", 64'(write_enable), 64'd0);
    check("mid_rst_count", 64'(pending_count), 64'd0);
    check("mid_rst_ready", 64'(request_ready), 64'd1);
    check("mid_rst_wdata", 64'(write_data), 64'd0);
    check("mid_rst_hit0", 64'(bypass_hit_port_0), 64'd0);
    step();
    check("mid_rst_we_later", 64'(write_enable), 64'd0);
    check("mid_rst_count_later", 64'(pending_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
